// File: rtl/except_ctrl_pkg.sv
// Shared constants for the exception sequencer: CP0 exception codes, CP0 register
// addresses, MEM-stage flag positions, stall patterns and FSM state encodings.
package except_ctrl_pkg;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int FLAG_SYSCALL = 8;
    localparam int FLAG_INVALID = 9;
    localparam int FLAG_TRAP    = 10;
    localparam int FLAG_OV      = 11;
    localparam int FLAG_ERET    = 12;

    // Only the software-interrupt bits (9:8) and IV/WP (23:22) of Cause are writable.
    localparam logic [31:0] CAUSE_WR_MASK = 32'h00C0_0300;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    function automatic logic irq_pending(input logic [31:0] status, input logic [31:0] cause);
        return (|(cause[15:8] & status[15:8])) && status[0] && !status[1];
    endfunction

endpackage

// File: rtl/except_ctrl_cp0_fwd.sv
// Forwards an in-flight WB-stage CP0 write onto the Status/Cause/EPC values seen by
// the exception logic, so a write and an exception in the same cycle agree.
module cp0_fwd
    import except_ctrl_pkg::*;
(
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_waddr,
    input  logic [31:0] i_wb_data,
    input  logic [31:0] i_status,
    input  logic [31:0] i_cause,
    input  logic [31:0] i_epc,
    output logic [31:0] o_status,
    output logic [31:0] o_cause,
    output logic [31:0] o_epc
);

    // NOTE: every output gets a default before the case, so no path leaves a latch.
    always_comb begin
        o_status = i_status;
        o_cause  = i_cause;
        o_epc    = i_epc;
        if (i_wb_we) begin
            case (i_wb_waddr)
                CP0_STATUS: o_status = i_wb_data;
                CP0_CAUSE:  o_cause  = (i_cause & ~CAUSE_WR_MASK) | (i_wb_data & CAUSE_WR_MASK);
                CP0_EPC:    o_epc    = i_wb_data;
                default:    ;
            endcase
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// Exception/interrupt sequencer: prioritises MEM-stage exceptions and interrupts,
// flushes and redirects the pipeline, then masks everything for a drain window.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          DRAIN_CYCLES = 1,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic [31:0]      excflags_i,
    input  logic [31:0]      current_inst_addr_i,
    input  logic             is_in_delayslot_i,
    input  logic [31:0]      cp0_status_i,
    input  logic [31:0]      cp0_cause_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             wb_cp0_we_i,
    input  logic [4:0]       wb_cp0_waddr_i,
    input  logic [31:0]      wb_cp0_data_i,
    output logic [31:0]      excepttype_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic [5:0]       stall_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] exc_count_o
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [31:0]      w_eff_status;
    logic [31:0]      w_eff_cause;
    logic [31:0]      w_eff_epc;
    logic             w_int_pending;
    logic             w_idle;
    logic             w_detect_en;
    logic [31:0]      w_exc_code;
    logic             w_flush;
    logic             w_unused;

    logic [0:0]       r_state;
    logic [3:0]       r_drain_cnt;
    logic [CNT_W-1:0] r_exc_count;

    cp0_fwd u_cp0_fwd (
        .i_wb_we    (wb_cp0_we_i),
        .i_wb_waddr (wb_cp0_waddr_i),
        .i_wb_data  (wb_cp0_data_i),
        .i_status   (cp0_status_i),
        .i_cause    (cp0_cause_i),
        .i_epc      (cp0_epc_i),
        .o_status   (w_eff_status),
        .o_cause    (w_eff_cause),
        .o_epc      (w_eff_epc)
    );

    assign w_int_pending = irq_pending(w_eff_status, w_eff_cause);
    assign w_idle        = !rst && (r_state == ST_IDLE);
    // A bubble (PC 0) carries no precise restart point, so a pending interrupt waits.
    assign w_detect_en   = w_idle && (current_inst_addr_i != 32'd0);

    always_comb begin
        w_exc_code = EXC_NONE;
        if (w_detect_en) begin
            if (w_int_pending)                  w_exc_code = EXC_INT;
            else if (excflags_i[FLAG_INVALID])  w_exc_code = EXC_INVALID;
            else if (excflags_i[FLAG_TRAP])     w_exc_code = EXC_TRAP;
            else if (excflags_i[FLAG_SYSCALL])  w_exc_code = EXC_SYSCALL;
            else if (excflags_i[FLAG_OV])       w_exc_code = EXC_OV;
            else if (excflags_i[FLAG_ERET])     w_exc_code = EXC_ERET;
        end
    end

    assign w_flush      = (w_exc_code != EXC_NONE);
    assign excepttype_o = w_exc_code;
    assign flush_o      = w_flush;

    always_comb begin
        new_pc_o = 32'd0;
        if (w_flush) new_pc_o = (w_exc_code == EXC_ERET) ? w_eff_epc : EXC_VECTOR;
    end

    always_comb begin
        stall_o = STALL_NONE;
        if (w_idle && !w_flush) begin
            if (stallreq_ex_i)      stall_o = STALL_EX;
            else if (stallreq_id_i) stall_o = STALL_ID;
        end
    end

    assign busy_o      = (r_state != ST_IDLE);
    assign exc_count_o = r_exc_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_flush) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == 4'd0) r_state     <= ST_IDLE;
                    else                     r_drain_cnt <= r_drain_cnt - 4'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exc_count <= '0;
        end else if (w_flush && (w_exc_code != EXC_ERET) && (r_exc_count != '1)) begin
            r_exc_count <= r_exc_count + CNT_W'(1);
        end
    end

    // Delay-slot status and the unused flag/CP0 bits are consumed downstream, not here.
    assign w_unused = &{1'b0, is_in_delayslot_i, excflags_i[31:13], excflags_i[7:0],
                        w_eff_status[31:16], w_eff_status[7:2],
                        w_eff_cause[31:16], w_eff_cause[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: directed scenarios plus random traffic, all
// compared against a cycle-level behavioural model of the sequencer's rules.
module tb_except_ctrl;

    localparam int          DRAIN = 3;
    localparam int          CW    = 8;
    localparam logic [31:0] VEC   = 32'h0000_0020;
    localparam int          CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stallreq_id, stallreq_ex, delayslot, wb_we;
    logic [31:0]   flags, pc, status, cause, epc, wb_data;
    logic [4:0]    wb_waddr;
    logic [31:0]   excepttype_o, new_pc_o;
    logic          flush_o, busy_o;
    logic [5:0]    stall_o;
    logic [CW-1:0] exc_count_o;

    int total = 0;
    int bad   = 0;

    // Model state: remaining drain cycles (0 = idle) and taken-exception tally.
    int          m_drain = 0;
    int          m_count = 0;
    logic [31:0] e_type, e_pc;
    logic        e_flush;
    logic [5:0]  e_stall;

    except_ctrl #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stallreq_id_i       (stallreq_id),
        .stallreq_ex_i       (stallreq_ex),
        .excflags_i          (flags),
        .current_inst_addr_i (pc),
        .is_in_delayslot_i   (delayslot),
        .cp0_status_i        (status),
        .cp0_cause_i         (cause),
        .cp0_epc_i           (epc),
        .wb_cp0_we_i         (wb_we),
        .wb_cp0_waddr_i      (wb_waddr),
        .wb_cp0_data_i       (wb_data),
        .excepttype_o        (excepttype_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .stall_o             (stall_o),
        .busy_o              (busy_o),
        .exc_count_o         (exc_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        logic [31:0] st, ca, ep;
        logic        irq, idle;
        st = status; ca = cause; ep = epc;
        if (wb_we && wb_waddr == 5'd12) st = wb_data;
        if (wb_we && wb_waddr == 5'd13) ca = (cause & ~32'h00C0_0300) | (wb_data & 32'h00C0_0300);
        if (wb_we && wb_waddr == 5'd14) ep = wb_data;
        irq  = ((ca[15:8] & st[15:8]) != 8'd0) && st[0] && !st[1];
        idle = !rst && (m_drain == 0);
        e_type = 32'h0;
        if (idle && pc != 32'd0) begin
            if (irq)            e_type = 32'h1;
            else if (flags[9])  e_type = 32'ha;
            else if (flags[10]) e_type = 32'hd;
            else if (flags[8])  e_type = 32'h8;
            else if (flags[11]) e_type = 32'hc;
            else if (flags[12]) e_type = 32'he;
        end
        e_flush = (e_type != 32'h0);
        e_pc    = !e_flush ? 32'h0 : (e_type == 32'he ? ep : VEC);
        e_stall = 6'b0;
        if (idle && !e_flush) e_stall = stallreq_ex ? 6'b001111 : (stallreq_id ? 6'b000111 : 6'b0);
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        model_eval();
        check("type",   excepttype_o, e_type);
        check("flush",  32'(flush_o), 32'(e_flush));
        check("new_pc", new_pc_o, e_pc);
        check("stall",  32'(stall_o), 32'(e_stall));
        check("busy",   32'(busy_o), 32'(!rst && m_drain > 0));
        check("count",  32'(exc_count_o), rst ? 32'd0 : 32'(m_count));
        @(posedge clk);
        if (rst) begin
            m_drain = 0;
            m_count = 0;
        end else if (e_flush) begin
            m_drain = DRAIN;
            if (e_type != 32'he && m_count < CMAX) m_count++;
        end else if (m_drain > 0) begin
            m_drain--;
        end
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_id = 1'b0; stallreq_ex = 1'b0; delayslot = 1'b0;
        flags = 32'h0; pc = 32'h0; status = 32'h0; cause = 32'h0; epc = 32'h0;
        wb_we = 1'b0; wb_waddr = 5'd0; wb_data = 32'h0;
    endtask

    initial begin
        clear_inputs();
        flags = 32'h100; pc = 32'h100; stallreq_ex = 1'b1;
        #2;
        check("rst_type",  excepttype_o, 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        repeat (2) step();
        rst = 1'b0;
        clear_inputs();
        step();

        // Syscall
        flags = 32'h100; pc = 32'h100; status = 32'h1000_0000;
        #1;
        check("sys_type",   excepttype_o, 32'h8);
        check("sys_flush",  32'(flush_o), 32'h1);
        check("sys_new_pc", new_pc_o, 32'h20);
        step();
        check("sys_busy",   32'(busy_o), 32'h1);
        check("sys_flush2", 32'(flush_o), 32'h0);
        check("sys_count",  32'(exc_count_o), 32'h1);
        clear_inputs();
        repeat (DRAIN) step();

        // Interrupt deferred over a bubble
        cause = 32'h0000_0400; status = 32'h0000_0401; pc = 32'h0;
        #1;
        check("irq_bubble", excepttype_o, 32'h0);
        step();
        pc = 32'h104;
        #1;
        check("irq_type",  excepttype_o, 32'h1);
        check("irq_flush", 32'(flush_o), 32'h1);
        step();
        clear_inputs();
        repeat (DRAIN) step();

        // Eret with EPC forwarded from WB
        flags = 32'h1000; pc = 32'h108; epc = 32'h200;
        wb_we = 1'b1; wb_waddr = 5'd14; wb_data = 32'h300;
        #1;
        check("eret_type",   excepttype_o, 32'he);
        check("eret_new_pc", new_pc_o, 32'h300);
        step();
        check("eret_count",  32'(exc_count_o), 32'h2);
        clear_inputs();
        repeat (DRAIN) step();

        // Priority, then syscall masked for the whole drain window
        flags = 32'h0B00; pc = 32'h10c;
        #1;
        check("prio_type", excepttype_o, 32'ha);
        step();
        flags = 32'h100; stallreq_ex = 1'b1;
        for (int i = 0; i < DRAIN; i++) begin
            #1;
            check("drain_type",  excepttype_o, 32'h0);
            check("drain_stall", 32'(stall_o), 32'h0);
            step();
        end
        #1;
        check("post_drain_type", excepttype_o, 32'h8);
        step();
        clear_inputs();
        repeat (DRAIN) step();

        // Stall vector and exception override
        stallreq_ex = 1'b1; pc = 32'h110;
        #1;
        check("stall_ex", 32'(stall_o), 32'h0f);
        step();
        stallreq_ex = 1'b0; stallreq_id = 1'b1;
        #1;
        check("stall_id", 32'(stall_o), 32'h07);
        step();
        stallreq_id = 1'b0; stallreq_ex = 1'b1; flags = 32'h800;
        #1;
        check("ov_stall", 32'(stall_o), 32'h0);
        check("ov_flush", 32'(flush_o), 32'h1);
        check("ov_type",  excepttype_o, 32'hc);
        step();
        clear_inputs();
        repeat (DRAIN) step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            flags       = ($urandom & $urandom & 32'h0000_1F00) | ($urandom & 32'hFFFF_E0FF);
            pc          = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            status      = $urandom;
            cause       = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
            epc         = $urandom;
            wb_we       = 1'($urandom_range(0, 1));
            wb_waddr    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 2));
            wb_data     = $urandom;
            stallreq_id = 1'($urandom_range(0, 1));
            stallreq_ex = 1'($urandom_range(0, 2) == 0);
            delayslot   = 1'($urandom_range(0, 1));
            step();
        end
        clear_inputs();
        repeat (DRAIN + 1) step();

        // Asynchronous reset in the middle of a drain window
        flags = 32'h100; pc = 32'h100; stallreq_ex = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  32'(busy_o), 32'h0);
        check("mid_rst_count", 32'(exc_count_o), 32'h0);
        check("mid_rst_type",  excepttype_o, 32'h0);
        check("mid_rst_flush", 32'(flush_o), 32'h0);
        m_drain = 0;
        m_count = 0;
        step();
        rst = 1'b0;
        clear_inputs();
        step();

        // Counter saturation: 2^CW + 3 back-to-back syscalls
        flags = 32'h100; pc = 32'h100;
        repeat (((1 << CW) + 3) * (DRAIN + 1)) step();
        check("sat_count", 32'(exc_count_o), 32'(CMAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
